// File: rtl/indexed_stack.sv
// Parametrised LIFO holding placed-queen columns for the N-Queen solver.
// Supports push, pop, replace-top, peek below top, flush, sticky error flags and a post-reset clear.

module stack_controller (
    input  logic clk,
    input  logic reset,
    input  logic clr_last,
    output logic ready,
    output logic clear_en
);
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        clear_en   = 1'b0;
        case (state)
            CLEAR: begin
                clear_en = 1'b1;
                if (clr_last) state_next = IDLE;
            end
            IDLE: begin
                ready = 1'b1;
            end
            default: state_next = CLEAR;
        endcase
    end
endmodule

module stack_datapath #(
    parameter int DEPTH = 8,
    parameter int SIZE  = 6,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    input  logic            clear_en,
    input  logic            user_push,
    input  logic            user_pop,
    input  logic            flush,
    input  logic            clear_flags,
    input  logic [SIZE-1:0] bus_in,
    input  logic [IW-1:0]   peek_idx,
    output logic            clr_last,
    output logic [SIZE-1:0] bus_out,
    output logic [SIZE-1:0] peek_data,
    output logic            peek_valid,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);
    logic [SIZE-1:0] mem [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic [IW-1:0]   clr_ptr;
    logic [IW-1:0]   top_addr;
    logic [IW-1:0]   push_addr;
    logic [IW-1:0]   peek_addr;
    logic            wr_en;
    logic [IW-1:0]   wr_addr;
    logic [SIZE-1:0] wr_data;
    logic            ov_set;
    logic            un_set;

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign clr_last  = (clr_ptr == IW'(DEPTH - 1));
    // Only dereferenced when count_q>0 (top) or count_q<DEPTH (push), so truncation is safe.
    assign top_addr  = IW'(count_q - CW'(1));
    assign push_addr = IW'(count_q);
    assign peek_addr = IW'(count_q - CW'(1) - CW'(peek_idx));

    assign peek_valid = (CW'(peek_idx) < count_q);
    assign peek_data  = peek_valid ? mem[peek_addr] : '0;
    assign bus_out    = empty ? '0 : mem[top_addr];

    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        count_next = count_q;
        ov_set     = 1'b0;
        un_set     = 1'b0;
        if (clear_en) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr;
        end else if (ready && flush) begin
            count_next = '0;
        end else if (ready && user_push && user_pop) begin
            wr_en   = 1'b1;
            wr_data = bus_in;
            if (empty) begin
                wr_addr    = '0;
                count_next = CW'(1);
            end else begin
                wr_addr = top_addr;
            end
        end else if (ready && user_push) begin
            if (full) begin
                ov_set = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_addr    = push_addr;
                wr_data    = bus_in;
                count_next = count_q + CW'(1);
            end
        end else if (ready && user_pop) begin
            if (empty) un_set = 1'b1;
            else       count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            clr_ptr   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count_q <= count_next;
            if (clear_en) clr_ptr <= clr_last ? '0 : clr_ptr + IW'(1);
            // A new error outranks a coincident clear request.
            if (ov_set)           overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (un_set)           underflow <= 1'b1;
            else if (clear_flags) underflow <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset branch; the CLEAR sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_addr] <= wr_data;
    end
endmodule

module indexed_stack #(
    parameter int DEPTH = 8,
    parameter int SIZE  = 6,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            user_push,
    input  logic            user_pop,
    input  logic            flush,
    input  logic            clear_flags,
    input  logic [SIZE-1:0] bus_in,
    input  logic [IW-1:0]   peek_idx,
    output logic [SIZE-1:0] bus_out,
    output logic [SIZE-1:0] peek_data,
    output logic            peek_valid,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            underflow,
    output logic            ready
);
    logic clr_last;
    logic clear_en;

    stack_controller u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr_last (clr_last),
        .ready    (ready),
        .clear_en (clear_en)
    );

    stack_datapath #(
        .DEPTH (DEPTH),
        .SIZE  (SIZE)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .clear_en    (clear_en),
        .user_push   (user_push),
        .user_pop    (user_pop),
        .flush       (flush),
        .clear_flags (clear_flags),
        .bus_in      (bus_in),
        .peek_idx    (peek_idx),
        .clr_last    (clr_last),
        .bus_out     (bus_out),
        .peek_data   (peek_data),
        .peek_valid  (peek_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );
endmodule
